// File: rtl/ectrl_322_if.sv
// ectrl_322_if: control bus between the Viterbi decoder controller and its
// ACS / traceback datapath. Signal prefixes are relative to the controller
// (i_ = into the controller, o_ = out of it).
interface ectrl_322_if #(
    parameter int CNT_W = 7
);
    logic             i_start;
    logic             i_sym_valid;
    logic             o_sym_ready;
    logic [7:0]       i_pm_msb;
    logic             o_ae;
    logic             o_norm;
    logic             o_tb_start;
    logic             i_tb_done;
    logic [CNT_W-1:0] o_stage_cnt;
    logic             o_busy;
    logic             o_frame_done;

    // Datapath / stimulus side
    modport master (
        output i_start, i_sym_valid, i_pm_msb, i_tb_done,
        input  o_sym_ready, o_ae, o_norm, o_tb_start, o_stage_cnt, o_busy, o_frame_done
    );

    // Controller side
    modport slave (
        input  i_start, i_sym_valid, i_pm_msb, i_tb_done,
        output o_sym_ready, o_ae, o_norm, o_tb_start, o_stage_cnt, o_busy, o_frame_done
    );
endinterface

// File: rtl/ectrl_322.sv
// ectrl_322: frame controller for a Viterbi decoder. Sequences one ACS
// stage per accepted symbol, optionally inserts path-metric normalization
// cycles, then launches traceback and reports end of frame.
// Optional feature macro: ECTRL_322_NORM_EN (normalization when all eight
// path-metric MSBs are set). Without it, norm stays 0 and pm_msb is ignored.
module ectrl_322 #(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 7
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    ectrl_322_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_ACS, S_NORM, S_TBS, S_TBW, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(FRAME_LEN - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_stage_cnt;
    logic             r_ae;
    logic             r_norm;
    logic             r_tb_start;
    logic             r_frame_done;

    logic             w_norm_req;
    logic             w_hs;

`ifdef ECTRL_322_NORM_EN
    // All metrics past half range: rescale before they can overflow
    assign w_norm_req = &bus.i_pm_msb;
`else
    logic w_pm_unused;
    assign w_pm_unused = ^bus.i_pm_msb;
    assign w_norm_req  = 1'b0;
`endif

    // Normalization takes priority, so the symbol is held off while pending
    assign bus.o_sym_ready = (r_state == S_RUN) & ~w_norm_req;
    assign w_hs            = bus.i_sym_valid & bus.o_sym_ready;

    // Frame sequencer with registered single-cycle strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_stage_cnt  <= '0;
            r_ae         <= 1'b0;
            r_norm       <= 1'b0;
            r_tb_start   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_ae         <= 1'b0;
            r_norm       <= 1'b0;
            r_tb_start   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_state     <= S_RUN;
                        r_stage_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_norm_req) begin
                        r_state <= S_NORM;
                        r_norm  <= 1'b1;
                    end else if (w_hs) begin
                        r_state <= S_ACS;
                        r_ae    <= 1'b1;
                    end
                end
                S_ACS: begin
                    // Count only advances here and stops at FRAME_LEN
                    r_stage_cnt <= r_stage_cnt + 1'b1;
                    if (r_stage_cnt == LAST_STAGE) begin
                        r_state    <= S_TBS;
                        r_tb_start <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_NORM:  r_state <= S_RUN;
                S_TBS:   r_state <= S_TBW;
                S_TBW: begin
                    if (bus.i_tb_done) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ae         = r_ae;
    assign bus.o_norm       = r_norm;
    assign bus.o_tb_start   = r_tb_start;
    assign bus.o_frame_done = r_frame_done;
    assign bus.o_stage_cnt  = r_stage_cnt;
    assign bus.o_busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_ectrl_322.sv
// tb_ectrl_322: randomized bench for ectrl_322 with FRAME_LEN=4. The
// reference model schedules expected strobes by cycle number from the
// handshake / traceback events it sees on the inputs.
module tb_ectrl_322;
    localparam int FL = 4;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ectrl_322_if #(.CNT_W(CW)) bus ();

    ectrl_322 #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model state
    int cyc = 0;
    bit in_frame, tbph, done_s, hs;
    int next_run, tb_cyc, done_cyc, stages, cnt, pend_cyc, pend_val;
    bit sch_ae[int], sch_nm[int], sch_tbs[int], sch_fd[int];

    function automatic bit nreq();
`ifdef ECTRL_322_NORM_EN
        return bus.i_pm_msb == 8'hFF;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        in_frame = 0; tbph = 0; done_s = 0; hs = 0;
        cnt = 0; stages = 0; pend_cyc = -1; next_run = -1; tb_cyc = -1; done_cyc = -1;
        sch_ae.delete(); sch_nm.delete(); sch_tbs.delete(); sch_fd.delete();
    endtask

    // One clock: check this cycle's outputs, advance the model, move on
    task automatic tick();
        @(negedge clk);
        if (cyc == pend_cyc) cnt = pend_val;
        chk("ae",    bus.o_ae,         32'(sch_ae.exists(cyc)));
        chk("norm",  bus.o_norm,       32'(sch_nm.exists(cyc)));
        chk("tbs",   bus.o_tb_start,   32'(sch_tbs.exists(cyc)));
        chk("fdone", bus.o_frame_done, 32'(sch_fd.exists(cyc)));
        chk("busy",  bus.o_busy,       32'(in_frame));
        chk("rdy",   bus.o_sym_ready,  32'(in_frame && !tbph && cyc == next_run && !nreq()));
        chk("cnt",   bus.o_stage_cnt,  32'(cnt));
        hs = 0;
        if (!in_frame) begin
            if (bus.i_start) begin
                in_frame = 1; tbph = 0; done_s = 0; stages = 0;
                next_run = cyc + 1; pend_cyc = cyc + 1; pend_val = 0;
            end
        end else if (tbph) begin
            if (!done_s && cyc > tb_cyc && bus.i_tb_done) begin
                done_s = 1; done_cyc = cyc + 1; sch_fd[cyc+1] = 1;
            end else if (done_s && cyc == done_cyc) begin
                in_frame = 0;
            end
        end else if (cyc == next_run) begin
            if (nreq()) begin
                sch_nm[cyc+1] = 1; next_run = cyc + 2;
            end else if (bus.i_sym_valid) begin
                hs = 1; stages++;
                sch_ae[cyc+1] = 1; pend_cyc = cyc + 2; pend_val = stages;
                if (stages == FL) begin
                    tbph = 1; tb_cyc = cyc + 2; sch_tbs[cyc+2] = 1;
                end else begin
                    next_run = cyc + 2;
                end
            end else begin
                next_run = cyc + 1;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ae",   bus.o_ae,         0);
        chk("rst_norm", bus.o_norm,       0);
        chk("rst_tbs",  bus.o_tb_start,   0);
        chk("rst_fd",   bus.o_frame_done, 0);
        chk("rst_busy", bus.o_busy,       0);
        chk("rst_rdy",  bus.o_sym_ready,  0);
        chk("rst_cnt",  bus.o_stage_cnt,  0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    // mode 0: valid held, tb_done 3 cycles after tb_start
    // mode 1: 5-cycle valid gaps, random start/tb_done noise
    // mode 2: fully random valid/start/tb_done
    // pmm 0: pm_msb 0, 1: random with frequent 8'hFF, 2: 8'hFF throughout
    task automatic run_frame(input int mode, input int pmm);
        int gcnt = 0;
        int n;
        bus.i_start = 1'b1; bus.i_sym_valid = 1'b0; bus.i_tb_done = 1'b0; bus.i_pm_msb = 8'h00;
        tick();
        bus.i_start = 1'b0;
        for (n = 0; n < 400 && in_frame; n++) begin
            case (mode)
                0:       bus.i_sym_valid = 1'b1;
                1:       bus.i_sym_valid = (gcnt >= 5);
                default: bus.i_sym_valid = 1'($urandom % 2);
            endcase
            case (pmm)
                0:       bus.i_pm_msb = 8'h00;
                1:       bus.i_pm_msb = ($urandom % 4 == 0) ? 8'hFF :
                                        ($urandom % 2 == 0) ? 8'h7F : 8'($urandom % 255);
                default: bus.i_pm_msb = 8'hFF;
            endcase
            bus.i_start   = (mode == 0) ? 1'b0 : 1'($urandom % 3 == 0);
            bus.i_tb_done = (mode == 0) ? (tbph && cyc == tb_cyc + 3) : 1'($urandom % 4 == 0);
            tick();
            gcnt = hs ? 0 : gcnt + 1;
        end
        if (in_frame) chk("timeout", 1, 0);
        bus.i_start = 1'b0; bus.i_sym_valid = 1'b0; bus.i_tb_done = 1'b0; bus.i_pm_msb = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        int n;
        bus.i_start = 1'b0; bus.i_sym_valid = 1'b0; bus.i_tb_done = 1'b0; bus.i_pm_msb = 8'h00;
        model_clear();
        #1;
        do_reset();
        for (int i = 0; i < 3; i++) tick();

        run_frame(0, 0);
`ifdef ECTRL_322_NORM_EN
        run_frame(0, 1);
`else
        run_frame(0, 2);
`endif
        run_frame(1, 0);
        run_frame(1, 1);

        // Reset while in the ACS cycle of the third stage
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0; bus.i_sym_valid = 1'b1;
        for (n = 0; n < 50 && !(sch_ae.exists(cyc) && cnt == 2); n++) tick();
        if (n == 50) chk("acs_wait", 1, 0);
        chk("pre_rst_ae",   bus.o_ae,   1);
        chk("pre_rst_busy", bus.o_busy, 1);
        do_reset();
        bus.i_sym_valid = 1'b0;
        tick();
        run_frame(0, 0);

        for (int i = 0; i < 25; i++) run_frame(2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
